// File: rtl/cpu_pkg.sv
// Shared constants for the data-memory arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    // Arbiter FSM encoding
    typedef enum logic {
        ARB_S    = 1'b0,
        DBURST_S = 1'b1
    } arb_state_t;

    // Byte-strobe value that marks a read
    localparam logic [3:0]  BE_NONE        = 4'b0000;

    // Clears the byte offset so the memory only ever sees word addresses
    localparam logic [31:0] ADDR_WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundles the M-stage port, the secondary-master port and the DM array port.
// Latency: n/a (wires only).
// Backpressure: m_stall / d_gnt are driven by the arbiter through the slave modport.
interface dm_arbiter_if;

    // M-stage load/store port
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_stall;
    logic [31:0] m_rdata;
    logic        m_rvalid;

    // Secondary (debug/DMA) port
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_last;
    logic        d_gnt;
    logic [31:0] d_rdata;
    logic        d_rvalid;

    // Single-port DM array
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_stall, m_rdata, m_rvalid,
        input  d_req, d_we, d_be, d_addr, d_wdata, d_last,
        output d_gnt, d_rdata, d_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester + memory side
    modport master (
        output m_req, m_we, m_be, m_addr, m_wdata,
        input  m_stall, m_rdata, m_rvalid,
        output d_req, d_we, d_be, d_addr, d_wdata, d_last,
        input  d_gnt, d_rdata, d_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dm_rd_tracker.sv
// Remembers who issued the last memory read and steers the returning rvalid.
// Latency: rvalid one cycle after the granted read; reset clears it immediately.
// Backpressure: none, the requester must accept the returned word.
module dm_rd_tracker (
    input  logic clk,
    input  logic reset,
    input  logic i_rd_issue,
    input  logic i_rd_owner,
    output logic o_m_rvalid,
    output logic o_d_rvalid
);

    logic r_rd_pend;
    logic r_rd_owner;

    // Capture a read issued this cycle and which master owns its return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            r_rd_pend  <= i_rd_issue;
            r_rd_owner <= i_rd_owner;
        end
    end

    assign o_m_rvalid = r_rd_pend && !r_rd_owner;
    assign o_d_rvalid = r_rd_pend &&  r_rd_owner;

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port DM between the M-stage and a secondary burst master.
// Latency: grant is combinational; read data returns one cycle after the grant.
// Backpressure: M sees m_stall when it loses; secondary beats advance only on d_gnt.
module dm_arbiter
    import cpu_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic          clk,
    input  logic          reset,
    dm_arbiter_if.slave   bus
);

    arb_state_t  r_fsm;
    arb_state_t  w_fsm_nxt;
    logic [2:0]  r_wait_cnt;
    logic [2:0]  w_wait_nxt;
    logic [2:0]  r_beat_cnt;
    logic [2:0]  w_beat_nxt;

    logic        w_m_win;
    logic        w_d_win;
    logic        w_win_we;
    logic [3:0]  w_win_be;
    logic [31:0] w_win_addr;
    logic [31:0] w_win_wdata;
    logic        w_mem_en;
    logic [3:0]  w_mem_we;
    logic        w_rd_issue;

    // Grant decision: M has priority unless the secondary is starved or owns a burst
    always_comb begin
        w_m_win = 1'b0;
        w_d_win = 1'b0;
        if (!reset) begin
            case (r_fsm)
                ARB_S: begin
                    if (bus.d_req && (!bus.m_req || r_wait_cnt == 3'(STARVE_MAX)))
                        w_d_win = 1'b1;
                    else if (bus.m_req)
                        w_m_win = 1'b1;
                end
                DBURST_S: begin
                    w_d_win = bus.d_req;
                end
                default: ;
            endcase
        end
    end

    // Next-state, starvation counter and burst beat counter
    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_beat_nxt = r_beat_cnt;
        if (w_d_win || !bus.d_req)
            w_wait_nxt = 3'd0;
        else if (r_wait_cnt == 3'(STARVE_MAX))
            w_wait_nxt = r_wait_cnt;
        else
            w_wait_nxt = r_wait_cnt + 3'd1;

        case (r_fsm)
            ARB_S: begin
                if (w_d_win && !bus.d_last && (BURST_MAX > 1)) begin
                    w_fsm_nxt  = DBURST_S;
                    w_beat_nxt = 3'd1;
                end
            end
            DBURST_S: begin
                if (!bus.d_req) begin
                    // Secondary walked away mid-burst
                    w_fsm_nxt  = ARB_S;
                    w_beat_nxt = 3'd0;
                    w_wait_nxt = 3'd0;
                end else if (w_d_win) begin
                    if (bus.d_last || (r_beat_cnt + 3'd1 == 3'(BURST_MAX))) begin
                        w_fsm_nxt  = ARB_S;
                        w_beat_nxt = 3'd0;
                        w_wait_nxt = 3'd0;
                    end else begin
                        w_beat_nxt = r_beat_cnt + 3'd1;
                    end
                end
            end
            default: begin
                w_fsm_nxt  = ARB_S;
                w_beat_nxt = 3'd0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm      <= ARB_S;
            r_wait_cnt <= 3'd0;
            r_beat_cnt <= 3'd0;
        end else begin
            r_fsm      <= w_fsm_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_beat_cnt <= w_beat_nxt;
        end
    end

    // Route the winner's command to the memory; everything is zero when idle
    always_comb begin
        w_win_we    = 1'b0;
        w_win_be    = BE_NONE;
        w_win_addr  = 32'd0;
        w_win_wdata = 32'd0;
        if (w_d_win) begin
            w_win_we    = bus.d_we;
            w_win_be    = bus.d_be;
            w_win_addr  = bus.d_addr;
            w_win_wdata = bus.d_wdata;
        end else if (w_m_win) begin
            w_win_we    = bus.m_we;
            w_win_be    = bus.m_be;
            w_win_addr  = bus.m_addr;
            w_win_wdata = bus.m_wdata;
        end
    end

    assign w_mem_en   = w_m_win || w_d_win;
    assign w_mem_we   = w_win_we ? w_win_be : BE_NONE;
    assign w_rd_issue = w_mem_en && (w_mem_we == BE_NONE);

    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_win_addr & ADDR_WORD_MASK;
    assign bus.mem_wdata = w_win_wdata;

    assign bus.m_stall   = bus.m_req && !w_m_win;
    assign bus.d_gnt     = w_d_win;

    // Memory read data fans out unregistered; rvalid says whose it is
    assign bus.m_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

    dm_rd_tracker u_rd_tracker (
        .clk        (clk),
        .reset      (reset),
        .i_rd_issue (w_rd_issue),
        .i_rd_owner (w_d_win),
        .o_m_rvalid (bus.m_rvalid),
        .o_d_rvalid (bus.d_rvalid)
    );

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - the pipeline M-stage (load/store port);
  - a secondary master (debug/DMA loader).
- Sits between the M-stage and the DM array. The DM array has a 1-cycle read latency.
- Arbitration is M-priority, with a starvation guard and bounded secondary bursts.
- Drives m_stall back to the hazard unit when the M-stage loses arbitration.

Parameters:
- STARVE_MAX, 4: consecutive cycles d_req may be refused before the secondary is forced a grant (1..7).
- BURST_MAX, 4: maximum beats the secondary may hold memory in one burst (1..7).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- m_req  in  1  M-stage access request, held until served
- m_we  in  1  M-stage write (1) / read (0)
- m_be  in  4  M-stage byte enables (write only)
- m_addr  in  32  M-stage byte address
- m_wdata  in  32  M-stage write data
- m_stall  out  1  M-stage request not served this cycle
- m_rdata  out  32  read data for the M-stage
- m_rvalid  out  1  m_rdata valid (cycle after the granted read)
- d_req  in  1  secondary request
- d_we  in  1  secondary write/read
- d_be  in  4  secondary byte enables
- d_addr  in  32  secondary address
- d_wdata  in  32  secondary write data
- d_last  in  1  final beat of the secondary burst
- d_gnt  out  1  secondary beat accepted this cycle
- d_rdata  out  32  read data for the secondary
- d_rvalid  out  1  d_rdata valid
- mem_en  out  1  memory access this cycle
- mem_we  out  4  byte write strobes (0 = read)
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid the cycle after mem_en with mem_we==0

Behaviour:
- Registered state:
  - fsm: ARB or D_BURST;
  - wait_cnt: 3 bits;
  - beat_cnt: 3 bits;
  - rd_pend;
  - rd_owner: 0 = M, 1 = D.
- Reset (async, any cycle, including mid-burst or with a read pending):
  - fsm = ARB; wait_cnt = 0; beat_cnt = 0; rd_pend = 0.
  - Outputs while reset is high: m_rvalid = 0, d_rvalid = 0, d_gnt = 0, mem_en = 0, mem_we = 0.
  - Reset drops any pending read return.
- ARB grant (combinational):
  - d wins if d_req && (!m_req || wait_cnt==STARVE_MAX); otherwise m wins if m_req.
- D_BURST grant:
  - d wins if d_req; m is always refused.
- Outputs:
  - m_stall = m_req && !m_win.
  - d_gnt = d_win.
  - mem_en = m_win || d_win.
  - mem_we = winner_we ? winner_be : 4'b0000.
  - mem_addr and mem_wdata are muxed from the winner; they are 0 when idle.
- wait_cnt:
  - 0 when d_win or !d_req;
  - otherwise increment, saturating at STARVE_MAX.
- FSM transitions:
  - ARB -> D_BURST when d_win && !d_last && BURST_MAX>1; beat_cnt = 1 on entry.
  - D_BURST, per granted beat: beat_cnt++.
  - D_BURST -> ARB when any of:
    - d_win && d_last;
    - d_win && beat_cnt+1==BURST_MAX;
    - !d_req (secondary abandons the burst).
  - On return to ARB: beat_cnt = 0, wait_cnt = 0.
- Read return:
  - rd_pend <= mem_en && mem_we==0; rd_owner <= d_win.
  - Next cycle: m_rvalid = rd_pend && !rd_owner; d_rvalid = rd_pend && rd_owner.
  - m_rdata = d_rdata = mem_rdata, combinational pass-through.
- Simultaneous events:
  - A read return and a new grant in the same cycle are independent; back-to-back reads give 1 result per cycle.
  - m_req and d_req both asserted on the same cycle that wait_cnt reaches STARVE_MAX: d wins and m_stall = 1.
- Writes: no response beyond d_gnt or m_stall = 0; the memory commits on that edge.

Decomposition:
- Shared package cpu_pkg holds:
  - fsm state constants ARB_S = 1'b0, DBURST_S = 1'b1;
  - the BE_NONE = 4'b0000 constant;
  - word-align helper constant ADDR_WORD_MASK.
- One natural sub-module: dm_rd_tracker (rd_pend/rd_owner register and rvalid steering).

Test Plan:
- M-only: m_req=1, read 0x10 -> m_stall=0, mem_en=1, mem_we=0, mem_addr=0x10; next cycle m_rvalid=1, m_rdata=mem_rdata, d_rvalid=0.
- Contention, STARVE_MAX=4: m_req and d_req held high.
  - Cycles 0-3: m wins, wait_cnt 1..4.
  - Cycle 4: d_gnt=1, m_stall=1.
  - Cycle 5: m wins again.
- Burst, BURST_MAX=4: 6-beat d write burst with m_req=1.
  - d_gnt=1 for 4 consecutive cycles, then m served.
  - d_last honoured if it arrives earlier: a 2-beat burst releases after 2 beats.
- Burst abandon: enter D_BURST, drop d_req after 1 beat -> next cycle fsm=ARB, m_stall=0.
- Byte write: m_we=1, m_be=4'b0100, m_addr=0x7 -> mem_we=4'b0100, mem_addr=0x4, m_rvalid stays 0.
- Async reset mid-burst with a d read pending:
  - assert reset between edges -> d_rvalid=0 and mem_en=0 immediately;
  - after release, fsm=ARB and the first m_req is granted.
